// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_n
// Brief    : N-digit packed-BCD up/down counter with clear, validated load,
//            wrap/saturate bounds and terminal-count / pulse flags.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_n #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  tc,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] r_count;
  logic                r_overflow;
  logic                r_underflow;
  logic                r_load_err;

  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_load;
  logic [DIGITS:0]     w_cy;
  logic [DIGITS:0]     w_bw;
  logic [DIGITS-1:0]   w_bad;
  logic                w_all9;
  logic                w_all0;

  assign w_cy[0] = 1'b1;
  assign w_bw[0] = 1'b1;

  // Each decade is an independent 0..9 field; only carry/borrow ripples across.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_d;
    logic [3:0] w_lv;
    assign w_d  = r_count[4*i +: 4];
    assign w_lv = load_val[4*i +: 4];

    assign w_cy[i+1] = w_cy[i] & (w_d == 4'd9);
    assign w_bw[i+1] = w_bw[i] & (w_d == 4'd0);

    assign w_inc[4*i +: 4] = !w_cy[i] ? w_d : ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1);
    assign w_dec[4*i +: 4] = !w_bw[i] ? w_d : ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);

    assign w_bad[i]         = (w_lv > 4'd9);
    assign w_load[4*i +: 4] = w_bad[i] ? 4'd0 : w_lv;
  end

  assign w_all9 = w_cy[DIGITS];
  assign w_all0 = w_bw[DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_load_err  <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (load) begin
        r_count    <= w_load;
        r_load_err <= |w_bad;
      end else if (en) begin
        if (up) begin
          r_overflow <= w_all9;
          if (!(SATURATE && w_all9)) r_count <= w_inc;
        end else begin
          r_underflow <= w_all0;
          if (!(SATURATE && w_all0)) r_count <= w_dec;
        end
      end
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign load_err  = r_load_err;
  assign tc        = up ? w_all9 : w_all0;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_n
// Brief    : Directed self-checking bench for bcd_counter_n (wrap and saturate).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_val = '0;
  logic        en = 1'b0;
  logic        up = 1'b1;

  logic [11:0] w_count, s_count;
  logic        w_ovf, w_unf, w_tc, w_lerr;
  logic        s_ovf, s_unf, s_tc, s_lerr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(w_count), .overflow(w_ovf), .underflow(w_unf),
    .tc(w_tc), .load_err(w_lerr)
  );

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(s_count), .overflow(s_ovf), .underflow(s_unf),
    .tc(s_tc), .load_err(s_lerr)
  );

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    clr = 1'b0; en = 1'b0; load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (w_count !== 12'h000 || {w_ovf, w_unf, w_lerr} !== 3'b000) begin
      n_err++;
      $display("FAIL reset: count=%h flags=%b expected 000/000", w_count, {w_ovf, w_unf, w_lerr});
    end
    rst_n = 1'b1;
    #2;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_vec++;
      if (w_count !== to_bcd(i) || w_ovf !== 1'b0 || w_unf !== 1'b0) begin
        n_err++;
        $display("FAIL count_up[%0d]: count=%h ovf=%b unf=%b expected %h/0/0", i, w_count, w_ovf, w_unf, to_bcd(i));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_carry();
    do_load(12'h099);
    en = 1'b1; up = 1'b1;
    tick();
    n_vec++;
    if (w_count !== 12'h100 || w_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL carry_099: count=%h ovf=%b expected 100/0", w_count, w_ovf);
    end
    do_load(12'h999);
    up = 1'b1;
    #1;
    n_vec++;
    if (w_tc !== 1'b1) begin
      n_err++;
      $display("FAIL tc_999: tc=%b expected 1", w_tc);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    n_vec++;
    if (w_count !== 12'h000 || w_ovf !== 1'b1 || w_unf !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_up: count=%h ovf=%b unf=%b expected 000/1/0", w_count, w_ovf, w_unf);
    end
    tick();
    n_vec++;
    if (w_count !== 12'h000 || w_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_one_cycle: count=%h ovf=%b expected 000/0", w_count, w_ovf);
    end
  endtask

  task automatic test_borrow();
    do_load(12'h100);
    en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;
    n_vec++;
    if (w_count !== 12'h099 || w_unf !== 1'b0) begin
      n_err++;
      $display("FAIL borrow_100: count=%h unf=%b expected 099/0", w_count, w_unf);
    end
    do_load(12'h000);
    up = 1'b0;
    #1;
    n_vec++;
    if (w_tc !== 1'b1) begin
      n_err++;
      $display("FAIL tc_000_down: tc=%b expected 1", w_tc);
    end
    up = 1'b1;
    #1;
    n_vec++;
    if (w_tc !== 1'b0) begin
      n_err++;
      $display("FAIL tc_000_up: tc=%b expected 0", w_tc);
    end
    up = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    n_vec++;
    if (w_count !== 12'h999 || w_unf !== 1'b1 || w_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_down: count=%h unf=%b ovf=%b expected 999/1/0", w_count, w_unf, w_ovf);
    end
    tick();
    n_vec++;
    if (w_unf !== 1'b0) begin
      n_err++;
      $display("FAIL unf_one_cycle: unf=%b expected 0", w_unf);
    end
  endtask

  task automatic test_saturate();
    logic [11:0] exp_up [3];
    logic        exp_ov [3];
    logic [11:0] exp_dn [3];
    exp_up = '{12'h999, 12'h999, 12'h999};
    exp_ov = '{1'b0, 1'b1, 1'b1};
    exp_dn = '{12'h000, 12'h000, 12'h000};
    do_load(12'h998);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (s_count !== exp_up[i] || s_ovf !== exp_ov[i] || s_unf !== 1'b0) begin
        n_err++;
        $display("FAIL sat_up[%0d]: count=%h ovf=%b unf=%b expected %h/%b/0", i, s_count, s_ovf, s_unf, exp_up[i], exp_ov[i]);
      end
    end
    do_load(12'h001);
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (s_count !== exp_dn[i] || s_unf !== exp_ov[i] || s_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL sat_dn[%0d]: count=%h unf=%b ovf=%b expected %h/%b/0", i, s_count, s_unf, s_ovf, exp_dn[i], exp_ov[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    do_load(12'h321);
    clr = 1'b1; load = 1'b1; load_val = 12'h555; en = 1'b1; up = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0;
    n_vec++;
    if (w_count !== 12'h000 || w_lerr !== 1'b0) begin
      n_err++;
      $display("FAIL clr_priority: count=%h lerr=%b expected 000/0", w_count, w_lerr);
    end
    load = 1'b1; load_val = 12'h9A3; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    n_vec++;
    if (w_count !== 12'h903 || w_lerr !== 1'b1 || w_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL load_validate: count=%h lerr=%b ovf=%b expected 903/1/0", w_count, w_lerr, w_ovf);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (w_count !== 12'h903 || w_lerr !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: count=%h lerr=%b expected 903/0", i, w_count, w_lerr);
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(12'h456);
    en = 1'b1; up = 1'b1;
    tick();
    n_vec++;
    if (w_count !== 12'h457) begin
      n_err++;
      $display("FAIL pre_reset: count=%h expected 457", w_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (w_count !== 12'h000 || s_count !== 12'h000) begin
      n_err++;
      $display("FAIL async_reset: count=%h sat=%h expected 000", w_count, s_count);
    end
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    en = 1'b0;
    n_vec++;
    if (w_count !== 12'h001 || {w_ovf, w_unf, w_lerr} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset: count=%h flags=%b expected 001/000", w_count, {w_ovf, w_unf, w_lerr});
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_borrow();
    test_saturate();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
